vram_arbiter: RTL and testbench

Shares the single-port video RAM between three requesters: the display controller's pixel reads, the touch-driven paint writer, and an internal full-screen clear engine. The block sits between those requesters and the `block_ram` instance that backs the frame buffer. It grants at most one memory access per cycle. Display reads have priority, but a starvation counter guarantees that writes still make forward progress.

---
 rtl/vram_pkg.sv | 28 ++
 rtl/vram_arbiter_if.sv | 48 ++++
 rtl/vram_clear_engine.sv | 66 ++++++
 rtl/vram_arbiter.sv | 123 ++++++++++++
 tb/tb_vram_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vram_pkg.sv
// ---------------------------------------------------------------------------
// vram_pkg
// Shared types for the video RAM and everything that talks to it: the
// arbiter, the display controller and the paint logic.
//   VRAM_L       : frame buffer size in pixel words (240 x 320)
//   vram_addr_t  : pixel word address
//   vram_grant_t : which requester owns the RAM port this cycle
//   clr_state_t  : clear engine state
// ---------------------------------------------------------------------------
package vram_pkg;

   localparam int VRAM_L = 76800;

   typedef logic [16:0] vram_addr_t;

   typedef enum logic [1:0] {
      G_IDLE,
      G_DISP,
      G_PAINT,
      G_CLEAR
   } vram_grant_t;

   typedef enum logic {
      C_IDLE,
      C_FILL
   } clr_state_t;

endpackage

// File: rtl/vram_arbiter_if.sv
// ---------------------------------------------------------------------------
// vram_arbiter_if
// Bundles the requester-side and RAM-side signals of the VRAM arbiter.
//   slave  : the arbiter's view (requests and RAM read data in; grants,
//            status and RAM address/write controls out)
//   master : the environment's view (requesters and block_ram)
// Parameters: W = pixel word width, A = address width.
// ---------------------------------------------------------------------------
interface vram_arbiter_if #(
   parameter int W = 16,
   parameter int A = 17
);
   logic         disp_rd_valid;
   logic [A-1:0] disp_rd_addr;
   logic         disp_rd_ready;
   logic [W-1:0] disp_rd_data;
   logic         disp_rd_data_valid;

   logic         paint_valid;
   logic [A-1:0] paint_addr;
   logic [W-1:0] paint_data;
   logic         paint_ready;

   logic         clear_req;
   logic [W-1:0] clear_color;
   logic         clear_busy;
   logic         oob_error;

   logic [A-1:0] mem_addr;
   logic         mem_wr_ena;
   logic [W-1:0] mem_wr_data;
   logic [W-1:0] mem_rd_data;

   modport slave (
      input  disp_rd_valid, disp_rd_addr, paint_valid, paint_addr, paint_data,
             clear_req, clear_color, mem_rd_data,
      output disp_rd_ready, disp_rd_data, disp_rd_data_valid, paint_ready,
             clear_busy, oob_error, mem_addr, mem_wr_ena, mem_wr_data
   );

   modport master (
      output disp_rd_valid, disp_rd_addr, paint_valid, paint_addr, paint_data,
             clear_req, clear_color, mem_rd_data,
      input  disp_rd_ready, disp_rd_data, disp_rd_data_valid, paint_ready,
             clear_busy, oob_error, mem_addr, mem_wr_ena, mem_wr_data
   );

endinterface

// File: rtl/vram_clear_engine.sv
// ---------------------------------------------------------------------------
// vram_clear_engine
// Walks the whole frame buffer writing one fill color, one word per writer
// grant from the arbiter.
//   clk, rst : clock, synchronous active-high reset
//   start    : begin a clear (ignored while a clear is running)
//   color    : fill color, captured when start is accepted
//   grant    : arbiter granted the clear write this cycle
//   busy     : clear in progress
//   addr     : next word to write
//   data     : captured fill color
// ---------------------------------------------------------------------------
module vram_clear_engine
   import vram_pkg::*;
#(
   parameter int VRAM_L = vram_pkg::VRAM_L,
   parameter int W      = 16,
   parameter int A      = $clog2(VRAM_L)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [W-1:0] color,
   input  logic         grant,
   output logic         busy,
   output logic [A-1:0] addr,
   output logic [W-1:0] data
);

   localparam logic [A-1:0] LAST = A'(VRAM_L - 1);

   clr_state_t state;

   // data only changes on an accepted start, so it is left out of reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= C_IDLE;
         busy  <= 1'b0;
         addr  <= '0;
      end else begin
         case (state)
            C_IDLE: begin
               if (start) begin
                  state <= C_FILL;
                  busy  <= 1'b1;
                  addr  <= '0;
                  data  <= color;
               end
            end
            C_FILL: begin
               if (grant) begin
                  if (addr == LAST) begin
                     state <= C_IDLE;
                     busy  <= 1'b0;
                     addr  <= '0;
                  end else begin
                     addr <= addr + A'(1);
                  end
               end
            end
            default: state <= C_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/vram_arbiter.sv
// ---------------------------------------------------------------------------
// vram_arbiter
// Shares the single-port frame buffer RAM between display reads, paint
// writes and the full-screen clear engine. At most one access per cycle;
// the display wins ties, but a pending writer is never passed over more
// than STARVE_MAX cycles in a row.
//   clk, rst : clock, synchronous active-high reset
//   bus      : vram_arbiter_if.slave
//              display read port  (disp_rd_valid/addr/ready/data/data_valid)
//              paint write port   (paint_valid/addr/data/ready)
//              clear control      (clear_req/color/busy)
//              oob_error          sticky out-of-range paint flag
//              RAM port           (mem_addr/wr_ena/wr_data/rd_data, 1-cycle read)
// ---------------------------------------------------------------------------
module vram_arbiter
   import vram_pkg::*;
#(
   parameter int VRAM_L     = vram_pkg::VRAM_L,
   parameter int W          = 16,
   parameter int STARVE_MAX = 8
) (
   input  logic           clk,
   input  logic           rst,
   vram_arbiter_if.slave  bus
);

   localparam int              A          = $clog2(VRAM_L);
   localparam int              SW         = $clog2(STARVE_MAX + 1);
   localparam logic [SW-1:0]   STARVE_LIM = SW'(STARVE_MAX);
   localparam logic [A-1:0]    ADDR_END   = A'(VRAM_L);

   vram_grant_t   grant;
   vram_grant_t   writer;
   logic          wr_pending;
   logic          paint_oob;
   logic          clear_busy;
   logic [A-1:0]  clear_addr;
   logic [W-1:0]  clear_data;
   logic [SW-1:0] starve_cnt;
   logic          rd_vld_p1;
   logic          oob_q;

   vram_clear_engine #(
      .VRAM_L (VRAM_L),
      .W      (W),
      .A      (A)
   ) u_clear (
      .clk   (clk),
      .rst   (rst),
      .start (bus.clear_req),
      .color (bus.clear_color),
      .grant (grant == G_CLEAR),
      .busy  (clear_busy),
      .addr  (clear_addr),
      .data  (clear_data)
   );

   assign writer     = clear_busy ? G_CLEAR : G_PAINT;
   assign wr_pending = clear_busy | bus.paint_valid;
   assign paint_oob  = bus.paint_addr >= ADDR_END;

   // Reset forces the port idle so an interrupted clear issues no further write.
   always_comb begin
      grant = G_IDLE;
      if (!rst) begin
         if (wr_pending && starve_cnt == STARVE_LIM) grant = writer;
         else if (bus.disp_rd_valid)                 grant = G_DISP;
         else if (wr_pending)                        grant = writer;
      end
   end

   always_comb begin
      bus.mem_addr    = '0;
      bus.mem_wr_ena  = 1'b0;
      bus.mem_wr_data = '0;
      case (grant)
         G_DISP: begin
            bus.mem_addr = bus.disp_rd_addr;
         end
         G_PAINT: begin
            bus.mem_addr    = bus.paint_addr;
            bus.mem_wr_data = bus.paint_data;
            bus.mem_wr_ena  = ~paint_oob;
         end
         G_CLEAR: begin
            bus.mem_addr    = clear_addr;
            bus.mem_wr_data = clear_data;
            bus.mem_wr_ena  = 1'b1;
         end
         default: ;
      endcase
   end

   // starve_cnt counts display grants that a pending writer had to sit through
   always_ff @(posedge clk) begin
      if (rst) begin
         starve_cnt <= '0;
      end else if (!wr_pending || grant == G_CLEAR || grant == G_PAINT) begin
         starve_cnt <= '0;
      end else if (grant == G_DISP && starve_cnt != STARVE_LIM) begin
         starve_cnt <= starve_cnt + SW'(1);
      end
   end

   // ---- read response stage: RAM data returns one cycle after the grant ----
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_vld_p1 <= 1'b0;
         oob_q     <= 1'b0;
      end else begin
         rd_vld_p1 <= (grant == G_DISP);
         if (grant == G_PAINT && paint_oob) oob_q <= 1'b1;
      end
   end

   assign bus.disp_rd_ready      = (grant == G_DISP);
   assign bus.paint_ready        = (grant == G_PAINT);
   assign bus.disp_rd_data       = bus.mem_rd_data;
   assign bus.disp_rd_data_valid = rd_vld_p1;
   assign bus.clear_busy         = clear_busy;
   assign bus.oob_error          = oob_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_vram_arbiter
// Bench for vram_arbiter: a behavioural block_ram, a reference model of the
// arbitration rules and frame buffer contents, a table of single-cycle
// vectors, hand sequences for the multi-cycle cases and a random phase.
// ---------------------------------------------------------------------------
module tb_vram_arbiter;

   localparam int VRAM_L     = 76800;
   localparam int W          = 16;
   localparam int A          = 17;
   localparam int STARVE_MAX = 8;

   localparam int GI = 0, GD = 1, GP = 2, GC = 3;

   typedef vram_pkg::vram_addr_t addr_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   vram_arbiter_if #(.W(W), .A(A)) bus ();

   vram_arbiter #(
      .VRAM_L     (VRAM_L),
      .W          (W),
      .STARVE_MAX (STARVE_MAX)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // block_ram stand-in: read-first, 1-cycle read latency
   logic [W-1:0] ram [0:VRAM_L-1];
   always @(posedge clk) begin
      if (bus.mem_wr_ena) ram[bus.mem_addr] <= bus.mem_wr_data;
      bus.mem_rd_data <= ram[bus.mem_addr];
   end

   // reference model state
   logic [W-1:0] ref_mem [0:VRAM_L-1];
   int           m_wait;       // consecutive cycles a pending writer was passed over
   int           m_clr_left;   // words still to clear, 0 = no clear running
   logic [W-1:0] m_clr_color;
   logic         m_oob;
   logic         m_rd_pend;
   logic [W-1:0] m_rd_exp;

   // values seen in the latest step
   logic         o_drdy, o_prdy, o_we, o_rdv, o_busy, o_oob;
   logic [W-1:0] o_rdd, o_wdata;
   addr_t        o_addr;

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_wait     = 0;
      m_clr_left = 0;
      m_oob      = 1'b0;
      m_rd_pend  = 1'b0;
   endtask

   // Called at a falling edge: drive one cycle of inputs, check, advance the model.
   task automatic step(input logic dv, input addr_t da, input logic pv, input addr_t pa,
                       input logic [W-1:0] pd, input logic cr, input logic [W-1:0] cc);
      int   g;
      logic busy_now, wpend;
      int   caddr;
      bus.disp_rd_valid = dv;
      bus.disp_rd_addr  = da;
      bus.paint_valid   = pv;
      bus.paint_addr    = pa;
      bus.paint_data    = pd;
      bus.clear_req     = cr;
      bus.clear_color   = cc;
      #1;
      o_drdy = bus.disp_rd_ready;   o_prdy  = bus.paint_ready;
      o_we   = bus.mem_wr_ena;      o_addr  = bus.mem_addr;
      o_wdata = bus.mem_wr_data;    o_rdv   = bus.disp_rd_data_valid;
      o_rdd  = bus.disp_rd_data;    o_busy  = bus.clear_busy;
      o_oob  = bus.oob_error;

      chk("m_clear_busy", o_busy, m_clr_left != 0);
      chk("m_rd_valid", o_rdv, m_rd_pend);
      if (m_rd_pend) chk("m_rd_data", o_rdd, m_rd_exp);
      chk("m_oob_error", o_oob, m_oob);

      busy_now = (m_clr_left != 0);
      wpend    = busy_now || pv;
      if (wpend && m_wait >= STARVE_MAX) g = busy_now ? GC : GP;
      else if (dv)                       g = GD;
      else if (wpend)                    g = busy_now ? GC : GP;
      else                               g = GI;

      chk("m_disp_ready", o_drdy, g == GD);
      chk("m_paint_ready", o_prdy, g == GP);
      caddr = VRAM_L - m_clr_left;
      case (g)
         GD: begin
            chk("m_rd_addr", o_addr, da);
            chk("m_rd_we", o_we, 0);
         end
         GP: begin
            chk("m_pt_addr", o_addr, pa);
            chk("m_pt_we", o_we, int'(pa) < VRAM_L);
            if (int'(pa) < VRAM_L) chk("m_pt_data", o_wdata, pd);
         end
         GC: begin
            chk("m_cl_addr", o_addr, caddr);
            chk("m_cl_we", o_we, 1);
            chk("m_cl_data", o_wdata, m_clr_color);
         end
         default: begin
            chk("m_idle_addr", o_addr, 0);
            chk("m_idle_we", o_we, 0);
            chk("m_idle_data", o_wdata, 0);
         end
      endcase

      m_wait    = (wpend && g == GD) ? m_wait + 1 : 0;
      m_rd_pend = (g == GD);
      if (g == GD) m_rd_exp = ref_mem[int'(da)];
      if (g == GP) begin
         if (int'(pa) < VRAM_L) ref_mem[int'(pa)] = pd;
         else                   m_oob = 1'b1;
      end
      if (g == GC) begin
         ref_mem[caddr] = m_clr_color;
         m_clr_left--;
      end
      if (cr && !busy_now) begin
         m_clr_left  = VRAM_L;
         m_clr_color = cc;
      end
      @(negedge clk);
   endtask

   task automatic idle_step();
      step(1'b0, '0, 1'b0, '0, '0, 1'b0, '0);
   endtask

   task automatic do_reset();
      bus.disp_rd_valid = 1'b0; bus.disp_rd_addr = '0;
      bus.paint_valid   = 1'b0; bus.paint_addr   = '0; bus.paint_data = '0;
      bus.clear_req     = 1'b0; bus.clear_color  = '0;
      rst = 1'b1;
      #1;
      chk("rst_mem_we", bus.mem_wr_ena, 0);
      chk("rst_mem_addr", bus.mem_addr, 0);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   typedef struct {
      logic         dv;
      addr_t        da;
      logic         pv;
      addr_t        pa;
      logic [W-1:0] pd;
      logic         e_drdy;
      logic         e_prdy;
      logic         e_we;
   } vec_t;

   vec_t tbl [8];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int run, max_run, busy_cycles;
      logic pv;

      tbl[0] = '{1'b0, 17'd0,     1'b0, 17'd0,      16'h0000, 1'b0, 1'b0, 1'b0};
      tbl[1] = '{1'b1, 17'd3,     1'b0, 17'd0,      16'h0000, 1'b1, 1'b0, 1'b0};
      tbl[2] = '{1'b0, 17'd0,     1'b1, 17'd7,      16'hABCD, 1'b0, 1'b1, 1'b1};
      tbl[3] = '{1'b1, 17'd7,     1'b1, 17'd9,      16'h5555, 1'b1, 1'b0, 1'b0};
      tbl[4] = '{1'b0, 17'd0,     1'b1, 17'd76800,  16'hDEAD, 1'b0, 1'b1, 1'b0};
      tbl[5] = '{1'b0, 17'd0,     1'b1, 17'd76799,  16'h0F0F, 1'b0, 1'b1, 1'b1};
      tbl[6] = '{1'b1, 17'd76799, 1'b0, 17'd0,      16'h0000, 1'b1, 1'b0, 1'b0};
      tbl[7] = '{1'b0, 17'd0,     1'b1, 17'h1FFFF,  16'h7777, 1'b0, 1'b1, 1'b0};

      for (int i = 0; i < VRAM_L; i++) begin
         ram[i]     = W'(i);
         ref_mem[i] = W'(i);
      end

      do_reset();

      // reset state
      idle_step();
      chk("reset_busy", o_busy, 0);
      chk("reset_rd_valid", o_rdv, 0);
      chk("reset_oob", o_oob, 0);
      chk("reset_mem_we", o_we, 0);
      chk("reset_mem_addr", o_addr, 0);
      chk("reset_mem_wdata", o_wdata, 0);

      // display alone, addresses 0..9
      for (int i = 0; i <= 10; i++) begin
         step(i < 10, addr_t'(i), 1'b0, '0, '0, 1'b0, '0);
         chk("disp_alone_rdy", o_drdy, i < 10);
         chk("disp_alone_vld", o_rdv, i > 0);
         if (i > 0) chk("disp_alone_data", o_rdd, i - 1);
      end

      // paint alone then read back
      step(1'b0, '0, 1'b1, 17'd5, 16'h1234, 1'b0, '0);
      chk("paint_alone_rdy", o_prdy, 1);
      step(1'b1, 17'd5, 1'b0, '0, '0, 1'b0, '0);
      idle_step();
      chk("paint_readback", o_rdd, 16'h1234);

      // out-of-range paint
      step(1'b0, '0, 1'b1, 17'd76800, 16'hBEEF, 1'b0, '0);
      chk("oob_rdy", o_prdy, 1);
      chk("oob_we", o_we, 0);
      chk("oob_before", o_oob, 0);
      for (int i = 0; i < 3; i++) begin
         idle_step();
         chk("oob_sticky", o_oob, 1);
      end

      // single-cycle vector table, an idle cycle between entries
      for (int i = 0; i < 8; i++) begin
         step(tbl[i].dv, tbl[i].da, tbl[i].pv, tbl[i].pa, tbl[i].pd, 1'b0, '0);
         chk("tbl_disp_rdy", o_drdy, tbl[i].e_drdy);
         chk("tbl_paint_rdy", o_prdy, tbl[i].e_prdy);
         chk("tbl_wr_ena", o_we, tbl[i].e_we);
         idle_step();
      end

      // starvation: display and paint both always requesting
      run = 0; max_run = 0;
      for (int i = 0; i < 27; i++) begin
         step(1'b1, addr_t'($urandom_range(0, 63)), 1'b1, addr_t'($urandom_range(0, 63)),
              W'($urandom), 1'b0, '0);
         chk("starve_pattern", o_prdy, (i % 9) == 8);
         run = o_prdy ? 0 : run + 1;
         if (run > max_run) max_run = run;
      end
      chk("starve_max_wait", max_run, STARVE_MAX);
      idle_step();

      // random traffic, no clears
      for (int i = 0; i < 1500; i++) begin
         step($urandom_range(0, 3) != 0, addr_t'($urandom_range(0, 63)),
              1'($urandom_range(0, 1)),
              ($urandom_range(0, 31) == 0) ? addr_t'(VRAM_L + $urandom_range(0, 100))
                                           : addr_t'($urandom_range(0, 63)),
              W'($urandom), 1'b0, '0);
      end
      idle_step();

      // clear interrupted by reset after 100 words
      step(1'b0, '0, 1'b0, '0, '0, 1'b1, 16'hF800);
      for (int i = 0; i < 100; i++) idle_step();
      chk("abort_busy_before", o_busy, 1);
      do_reset();
      step(1'b1, 17'd98, 1'b0, '0, '0, 1'b0, '0);
      chk("abort_busy_after", o_busy, 0);
      step(1'b1, 17'd200, 1'b0, '0, '0, 1'b0, '0);
      chk("abort_addr98", o_rdd, 16'hF800);
      idle_step();
      chk("abort_addr200", o_rdd, 16'h00C8);

      // full clear with the display idle; paint requests stall throughout
      step(1'b0, '0, 1'b1, 17'd120, 16'h0A0A, 1'b1, 16'hF800);
      chk("clear_start_paint_rdy", o_prdy, 1);
      busy_cycles = 0;
      for (int i = 0; i < VRAM_L + 20; i++) begin
         pv = 1'($urandom_range(0, 1));
         step(1'b0, '0, pv, addr_t'($urandom_range(100, 163)), W'($urandom), 1'b0, '0);
         if (!o_busy) break;
         busy_cycles++;
         if (o_prdy) chk("clear_paint_stalled", o_prdy, 0);
      end
      chk("clear_duration", busy_cycles, VRAM_L);
      idle_step();
      step(1'b1, 17'd0, 1'b0, '0, '0, 1'b0, '0);
      step(1'b1, 17'd76799, 1'b0, '0, '0, 1'b0, '0);
      chk("clear_addr0", o_rdd, 16'hF800);
      idle_step();
      chk("clear_addr_last", o_rdd, 16'hF800);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end

endmodule
